// File: rtl/uart_pkg.sv
// Shared types for the UART receive control shell.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
//
// Contents:
//   parity_t    - parity setting presented to the receiver
//   rx_state_t  - frame tracker states
//   OVERSAMPLE  - receiver samples per bit
//   to_parity() - maps the raw 2-bit host encoding onto parity_t
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // The unused 2'b11 code means "no parity", so it is folded onto PAR_NONE
  // here and the receiver only ever sees one of the three legal codes.
  function automatic parity_t to_parity(input logic [1:0] raw);
    parity_t p;
    case (raw)
      2'b01:   p = PAR_EVEN;
      2'b10:   p = PAR_ODD;
      default: p = PAR_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO holding {parity_error, data} entries.
// Latency: a push is visible at the head one cycle later; head is combinational from the read pointer.
// Backpressure: a push into a full FIFO is refused unless a pop happens in the same cycle; a pop of an empty FIFO is ignored.
//
// Ports:
//   clk, reset_n     - clock, synchronous active-low reset
//   push, push_data  - write request and entry
//   pop              - remove the head entry
//   head             - current head entry (valid while !empty)
//   empty, full      - occupancy flags
//   count            - number of stored entries
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign empty  = (cnt == '0);
  assign full   = (cnt == FULL_CNT);
  assign do_pop = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign head  = mem[rd_ptr];
  assign count = cnt;

  // Storage carries no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Control shell for the 16x UART receiver: rx synchroniser, baud tick, frame tracking, deferred config, receive FIFO.
// Latency: rx_sync lags rx_pin by 2 clk; sample_tick is registered; received frames reach the FIFO head 1 clk after rx_done.
// Backpressure: none toward the receiver; a frame arriving at a full FIFO without a same-cycle pop is dropped and flagged as overrun.
//
// Ports:
//   clk, reset_n                        - clock, synchronous active-low reset
//   enable                              - run baud generator and frame tracker
//   rx_pin / rx_sync                    - raw serial input / synchronised copy for the receiver
//   cfg_wr, cfg_baud_div, cfg_parity    - host configuration write into the shadow
//   sample_tick, parity_mode            - timing and parity setting driven to the receiver
//   rx_done, rx_data, parity_error      - completed frame from the receiver
//   rd_en, rd_valid, rd_data, rd_perr   - host FIFO read side (first word fall through)
//   fifo_count                          - FIFO occupancy
//   busy, cfg_pending                   - frame in progress / shadow config not yet active
//   overrun, perr_seen, err_clr         - sticky status flags and their clear
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned TIMEOUT_TICKS = 200
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          rx_pin,
  input  logic                          cfg_wr,
  input  logic [DIV_W-1:0]              cfg_baud_div,
  input  logic [1:0]                    cfg_parity,
  output logic                          rx_sync,
  output logic                          sample_tick,
  output logic [1:0]                    parity_mode,
  input  logic                          rx_done,
  input  logic [7:0]                    rx_data,
  input  logic                          parity_error,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  output logic                          rd_perr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          cfg_pending,
  output logic                          overrun,
  output logic                          perr_seen,
  input  logic                          err_clr
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  // ---------------------------------------------------------------- sync
  logic sync1;
  logic sync2;

  // Preset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      sync2 <= sync1;
    end
  end

  assign rx_sync = sync2;

  // ---------------------------------------------------------------- config
  logic [DIV_W-1:0] baud_div;
  logic [DIV_W-1:0] shadow_div;
  parity_t          par_act;
  parity_t          shadow_par;
  logic             pending;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic             apply;

  // Changing the divisor or parity mid-frame would corrupt the frame, so the
  // shadow only goes live while idle and the line is not showing a start bit.
  assign apply = (state == ST_IDLE) && sync2 && pending;

  // A cfg_wr coinciding with an apply lands in the shadow after the copy and
  // keeps pending set, so the newer value is applied on the following cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      baud_div   <= DIV_W'(1);
      par_act    <= PAR_NONE;
      shadow_div <= DIV_W'(1);
      shadow_par <= PAR_NONE;
      pending    <= 1'b0;
    end else begin
      if (apply) begin
        baud_div <= shadow_div;
        par_act  <= shadow_par;
        pending  <= 1'b0;
      end
      if (cfg_wr) begin
        shadow_div <= cfg_baud_div;
        shadow_par <= to_parity(cfg_parity);
        pending    <= 1'b1;
      end
    end
  end

  assign parity_mode = par_act;
  assign cfg_pending = pending;

  // ---------------------------------------------------------------- baud
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] div_eff;
  logic             tick;

  // A zero divisor degenerates to a tick every cycle.
  assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;

  // Applying a new divisor restarts the count so the first period is whole.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      tick     <= 1'b0;
    end else if (apply || !enable) begin
      baud_cnt <= '0;
      tick     <= 1'b0;
    end else if (baud_cnt == div_eff - DIV_W'(1)) begin
      baud_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + DIV_W'(1);
      tick     <= 1'b0;
    end
  end

  assign sample_tick = tick;

  // ---------------------------------------------------------------- frame tracker
  logic [TO_W-1:0] tick_cnt;
  logic [TO_W-1:0] tick_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
    end
  end

  // The receiver never reports a false start, so a frame that runs
  // TIMEOUT_TICKS ticks without rx_done is abandoned.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && !sync2) begin
            state_nxt    = ST_FRAME;
            tick_cnt_nxt = '0;
          end
        end
        ST_FRAME: begin
          if (rx_done) begin
            state_nxt = ST_IDLE;
          end else if (tick) begin
            if (tick_cnt == TO_LAST) begin
              state_nxt = ST_IDLE;
            end else begin
              tick_cnt_nxt = tick_cnt + TO_W'(1);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_FRAME);

  // ---------------------------------------------------------------- FIFO
  logic [8:0] head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       drop;
  logic       pushed;

  // A full FIFO still takes the frame when the host pops in the same cycle.
  assign drop   = rx_done && fifo_full && !rd_en;
  assign pushed = rx_done && !drop;

  uart_rx_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_done),
    .push_data ({parity_error, rx_data}),
    .pop       (rd_en),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign rd_valid = !fifo_empty;
  assign rd_data  = head[7:0];
  assign rd_perr  = head[8];

  // ---------------------------------------------------------------- sticky flags
  // A set in the same cycle as err_clr wins, so no event is ever lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun   <= 1'b0;
      perr_seen <= 1'b0;
    end else begin
      overrun   <= drop || (overrun && !err_clr);
      perr_seen <= (pushed && parity_error) || (perr_seen && !err_clr);
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Control and buffering shell around the existing 16x-oversampling UART receiver.
- Synchronises the raw rx pin and generates the receiver's sample_tick from a programmable divisor.
- Owns the receiver's parity_mode and applies configuration changes only between frames.
- Captures completed frames (data plus parity error) into a small first-word-fall-through FIFO, with sticky overrun and parity status for the host.

Parameters:
- DIV_W, 16, width of baud divisor.
- FIFO_DEPTH, 8, receive FIFO entries; power of 2, ≥2.
- TIMEOUT_TICKS, 200, sample ticks after which a frame with no rx_done is abandoned (> 11 bits × 16).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  1 = run baud generator and frame tracking
- rx_pin  in  1  asynchronous serial input
- cfg_wr  in  1  one-cycle strobe, latch cfg_* into shadow
- cfg_baud_div  in  DIV_W  clk cycles per sample tick
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
- rx_sync  out  1  synchronised rx, drives receiver rx
- sample_tick  out  1  one-cycle tick to receiver
- parity_mode  out  2  active parity setting to receiver
- rx_done  in  1  receiver frame-complete pulse
- rx_data  in  8  receiver data, valid with rx_done
- parity_error  in  1  receiver parity flag, valid with rx_done
- rd_en  in  1  pop FIFO head
- rd_valid  out  1  FIFO non-empty
- rd_data  out  8  FIFO head data (FWFT)
- rd_perr  out  1  FIFO head parity-error bit
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- busy  out  1  frame in progress
- cfg_pending  out  1  shadow config not yet applied
- overrun  out  1  sticky, frame dropped on full FIFO
- perr_seen  out  1  sticky, any frame with parity error pushed
- err_clr  in  1  clear overrun and perr_seen

Behaviour:
- Reset (reset_n = 0 at posedge clk): active baud_div = 1, parity_mode = 00, shadow = same, cfg_pending = 0, state IDLE, baud counter 0.
  - sample_tick = 0, rx_sync = 1 (synchroniser flops preset to 1), FIFO empty, rd_valid = 0, fifo_count = 0, overrun = 0, perr_seen = 0, busy = 0.
  - Reset mid-frame or mid-config discards everything.
- Synchroniser: two flops; rx_sync lags rx_pin by 2 clk.
- Baud generator:
  - While enable = 1, the counter runs 0 .. div-1.
  - sample_tick is registered, high for the one cycle after count == div-1, then count returns to 0.
  - A div of 0 is treated as 1, giving a tick every cycle.
  - enable = 0: counter held at 0, no ticks, state forced to IDLE; FIFO contents kept.
- Frame tracker FSM (evaluated on sample_tick unless noted):
  - IDLE: rx_sync == 0 on a tick -> FRAME, tick_cnt = 0, busy = 1.
  - FRAME: tick_cnt increments per tick; rx_done (any cycle) -> IDLE.
  - FRAME: tick_cnt == TIMEOUT_TICKS-1 -> IDLE. This covers false starts, for which the receiver produces no rx_done.
- Configuration:
  - cfg_wr loads the shadow and sets cfg_pending.
  - Shadow is copied to active (baud_div, parity_mode) on the first cycle in IDLE with no rx_sync low. At that point cfg_pending clears and the baud counter restarts at 0.
  - cfg_wr in the same cycle as the apply: the new values are written to shadow and cfg_pending stays 1.
- FIFO push: on rx_done, entry {parity_error, rx_data}; perr_seen sets if parity_error = 1.
- Full FIFO with rx_done and no rd_en: frame dropped, overrun set, perr_seen unaffected.
- Full FIFO with rx_done and rd_en in the same cycle: pop and push both occur, no overrun.
- rd_en when empty: ignored. Simultaneous push and pop when empty: count goes to 1, rd_valid next cycle.
- rd_data/rd_perr show the head whenever rd_valid; they update the cycle after a pop.
- err_clr has priority below a same-cycle set, so an event coinciding with err_clr leaves the flag set.

Decomposition:
- Package uart_pkg:
  - parity_t enum (PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10).
  - OVERSAMPLE = 16.
  - Frame-tracker state enum {ST_IDLE, ST_FRAME}.
- Sub-module uart_rx_fifo: synchronous FWFT FIFO, width 9, depth FIFO_DEPTH, with wrap-around pointers, count, full/empty.
- Baud generator and synchroniser stay inline.

Test Plan:
- Reset, enable = 1, div = 4 -> first sample_tick 4 clk after enable, then one every 4 clk; div = 0 -> tick every clk.
- cfg_wr parity = 01 during FRAME -> parity_mode stays 00 and cfg_pending = 1 until rx_done; on the next idle cycle it becomes 01 and cfg_pending = 0.
- Push 3 frames 0x55, 0xA3 (perr = 1), 0x0F -> fifo_count = 3, rd_data = 0x55, perr_seen = 1; three pops return 0xA3/perr = 1 then 0x0F, rd_valid = 0.
- Fill 8 entries, a 9th rx_done with no rd_en -> dropped, overrun = 1, count = 8; 9th rx_done with rd_en -> count stays 8, no overrun.
- rx_sync low for 5 ticks with no rx_done -> busy deasserts after TIMEOUT_TICKS = 200 ticks; a pending config is applied afterwards.
- reset_n low mid-frame with 4 entries queued -> next cycle count = 0, busy = 0, flags 0, parity_mode = 00.
